// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the fetch/data memory port arbiter
// Purpose: FSM state and bus-owner encodings, plus the starvation counter width helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_ST_IDLE = 2'd0,
    ARB_ST_REQ  = 2'd1,
    ARB_ST_RSP  = 2'd2,
    ARB_ST_DONE = 2'd3
  } arb_state_e;

  typedef enum logic {
    ARB_OWNER_IF = 1'b0,
    ARB_OWNER_D  = 1'b1
  } arb_owner_e;

  // Width needed to count 0..starve_max; at least one bit so the counter
  // still exists (and stays at zero) in strict data-priority builds.
  function automatic int starve_cnt_wd(input int starve_max);
    return (starve_max > 0) ? $clog2(starve_max + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// rtl/mem_port_arbiter_pick.sv - combinational owner selection for the memory port arbiter
// Purpose: decide whether a transaction starts and who owns it.
// Ports:
//   d_req_i        data request
//   if_req_i       fetch request
//   if_kill_i      fetch redirect; a killed fetch is not eligible this cycle
//   starve_cnt_i   consecutive data grants made while fetch was waiting
//   pick_valid_o   a transaction should start
//   pick_if_o      1 = fetch owns it, 0 = data owns it
module mem_port_arbiter_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_WD     = starve_cnt_wd(STARVE_MAX)
) (
  input  logic              d_req_i,
  input  logic              if_req_i,
  input  logic              if_kill_i,
  input  logic [CNT_WD-1:0] starve_cnt_i,
  output logic              pick_valid_o,
  output logic              pick_if_o
);

  logic fetch_ok;
  logic fetch_forced;

  assign fetch_ok     = if_req_i & ~if_kill_i;
  // STARVE_MAX of zero disables forcing entirely: data always wins.
  assign fetch_forced = (STARVE_MAX != 0) && (starve_cnt_i == CNT_WD'(STARVE_MAX));

  assign pick_valid_o = d_req_i | fetch_ok;
  assign pick_if_o    = fetch_ok & (~d_req_i | fetch_forced);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-ported memory bus shared between fetch and data stages
// Purpose: one transaction in flight, data priority with a fetch starvation guard,
//          fetch kill support and combinational stall requests for the hazard unit.
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   if_req/if_addr/if_kill          fetch request, address, redirect
//   if_done/if_rdata/if_busy        fetch completion pulse, instruction, stall request
//   d_req/d_addr/d_we/d_wstrb/d_wdata  data request and store payload
//   d_done/d_rdata/d_busy           data completion pulse, load data, stall request
//   bus_req/bus_addr/bus_we/bus_wstrb/bus_wdata  registered bus request
//   bus_gnt/bus_rvalid/bus_rdata    bus accept and response
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WD    = 32,
  parameter int DATA_WD    = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_req,
  input  logic [ADDR_WD-1:0]   if_addr,
  input  logic                 if_kill,
  output logic                 if_done,
  output logic [DATA_WD-1:0]   if_rdata,
  output logic                 if_busy,
  input  logic                 d_req,
  input  logic [ADDR_WD-1:0]   d_addr,
  input  logic                 d_we,
  input  logic [DATA_WD/8-1:0] d_wstrb,
  input  logic [DATA_WD-1:0]   d_wdata,
  output logic                 d_done,
  output logic [DATA_WD-1:0]   d_rdata,
  output logic                 d_busy,
  output logic                 bus_req,
  output logic [ADDR_WD-1:0]   bus_addr,
  output logic                 bus_we,
  output logic [DATA_WD/8-1:0] bus_wstrb,
  output logic [DATA_WD-1:0]   bus_wdata,
  input  logic                 bus_gnt,
  input  logic                 bus_rvalid,
  input  logic [DATA_WD-1:0]   bus_rdata
);

  localparam int CNT_WD = starve_cnt_wd(STARVE_MAX);

  arb_state_e           state_q, state_d;
  arb_owner_e           owner_q, owner_d;
  logic                 kill_q, kill_d;
  logic [CNT_WD-1:0]    starve_q, starve_d;
  logic [ADDR_WD-1:0]   addr_q, addr_d;
  logic                 we_q, we_d;
  logic [DATA_WD/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_WD-1:0]   wdata_q, wdata_d;
  logic [DATA_WD-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_WD-1:0]   d_rdata_q, d_rdata_d;

  logic pick_valid;
  logic pick_if;

  mem_port_arbiter_pick #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_WD     (CNT_WD)
  ) u_pick (
    .d_req_i      (d_req),
    .if_req_i     (if_req),
    .if_kill_i    (if_kill),
    .starve_cnt_i (starve_q),
    .pick_valid_o (pick_valid),
    .pick_if_o    (pick_if)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ARB_ST_IDLE;
      owner_q    <= ARB_OWNER_IF;
      kill_q     <= 1'b0;
      starve_q   <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wstrb_q    <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      kill_q     <= kill_d;
      starve_q   <= starve_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wstrb_q    <= wstrb_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    kill_d     = kill_q;
    starve_d   = starve_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wstrb_d    = wstrb_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    // Starvation only counts while fetch is actually waiting.
    if (!if_req) begin
      starve_d = '0;
    end

    case (state_q)
      ARB_ST_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_ST_REQ;
          kill_d  = 1'b0;
          if (pick_if) begin
            owner_d  = ARB_OWNER_IF;
            addr_d   = if_addr;
            we_d     = 1'b0;
            wstrb_d  = '0;
            wdata_d  = '0;
            starve_d = '0;
          end else begin
            owner_d = ARB_OWNER_D;
            addr_d  = d_addr;
            we_d    = d_we;
            wstrb_d = d_wstrb;
            wdata_d = d_wdata;
            if (if_req && (starve_q != CNT_WD'(STARVE_MAX))) begin
              starve_d = starve_q + CNT_WD'(1);
            end
          end
        end
      end
      ARB_ST_REQ: begin
        // A killed fetch still completes on the bus; only its result is dropped.
        if (owner_q == ARB_OWNER_IF && if_kill) begin
          kill_d = 1'b1;
        end
        if (bus_gnt) begin
          state_d = ARB_ST_RSP;
        end
      end
      ARB_ST_RSP: begin
        if (owner_q == ARB_OWNER_IF && if_kill) begin
          kill_d = 1'b1;
        end
        if (bus_rvalid) begin
          state_d = ARB_ST_DONE;
          if (owner_q == ARB_OWNER_IF) begin
            if_rdata_d = bus_rdata;
          end else begin
            d_rdata_d = bus_rdata;
          end
        end
      end
      ARB_ST_DONE: begin
        kill_d  = 1'b0;
        state_d = ARB_ST_IDLE;
      end
      default: begin
        state_d = ARB_ST_IDLE;
      end
    endcase
  end

  assign bus_req   = (state_q == ARB_ST_REQ);
  assign bus_addr  = addr_q;
  assign bus_we    = we_q;
  assign bus_wstrb = wstrb_q;
  assign bus_wdata = wdata_q;

  // A kill arriving in the DONE cycle itself also suppresses the pulse.
  assign if_done  = (state_q == ARB_ST_DONE) && (owner_q == ARB_OWNER_IF) && !kill_q && !if_kill;
  assign d_done   = (state_q == ARB_ST_DONE) && (owner_q == ARB_OWNER_D);
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

  assign if_busy = if_req & ~if_done;
  assign d_busy  = d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_kill, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic        if_done, if_busy, d_done, d_busy;
  logic [31:0] if_rdata, d_rdata;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  logic        s_if_req, s_d_req, s_if_done, s_if_busy, s_d_done, s_d_busy;
  logic        s_bus_req, s_bus_we, s_bus_gnt, s_bus_rvalid;
  logic [31:0] s_if_rdata, s_d_rdata, s_bus_addr, s_bus_wdata, s_bus_rdata;
  logic [3:0]  s_bus_wstrb;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WD(32), .DATA_WD(32), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_done(if_done), .if_rdata(if_rdata), .if_busy(if_busy),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_busy(d_busy),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_we(bus_we), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  mem_port_arbiter #(.ADDR_WD(32), .DATA_WD(32), .STARVE_MAX(0)) dut_strict (
    .clk(clk), .reset(reset),
    .if_req(s_if_req), .if_addr(32'h0000_0200), .if_kill(1'b0),
    .if_done(s_if_done), .if_rdata(s_if_rdata), .if_busy(s_if_busy),
    .d_req(s_d_req), .d_addr(32'h0000_3000), .d_we(1'b0), .d_wstrb(4'h0), .d_wdata(32'h0),
    .d_done(s_d_done), .d_rdata(s_d_rdata), .d_busy(s_d_busy),
    .bus_req(s_bus_req), .bus_addr(s_bus_addr), .bus_we(s_bus_we), .bus_wstrb(s_bus_wstrb),
    .bus_wdata(s_bus_wdata), .bus_gnt(s_bus_gnt), .bus_rvalid(s_bus_rvalid), .bus_rdata(s_bus_rdata)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory content returned by the bus model.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'h0000_0013 : (a ^ 32'h5A5A_0000);
  endfunction

  typedef struct { logic is_fetch; logic [31:0] data; } exp_t;
  exp_t sb_q[$];

  task automatic push(input logic f, input logic [31:0] d);
    exp_t e;
    e.is_fetch = f;
    e.data     = d;
    sb_q.push_back(e);
  endtask

  // Monitor: every completion pulse is checked against the scoreboard.
  always @(negedge clk) begin
    if (reset && (if_done || d_done)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", {30'd0, if_done, d_done}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("done_owner_if", {31'd0, if_done}, {31'd0, e.is_fetch});
        chk("done_owner_d", {31'd0, d_done}, {31'd0, ~e.is_fetch});
        chk("done_rdata", if_done ? if_rdata : d_rdata, e.data);
      end
    end
  end

  // Bus model for the main DUT.
  int          gnt_wait = 0, gnt_delay = 0, rsp_wait = 0, rsp_delay = 0;
  logic        rsp_pend = 1'b0;
  logic [31:0] rsp_addr = 32'h0;
  initial begin
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      if (rsp_pend) begin
        if (rsp_wait > 0) rsp_wait--;
        else begin bus_rvalid = 1'b1; bus_rdata = mem_f(rsp_addr); rsp_pend = 1'b0; end
      end else if (bus_req) begin
        if (gnt_wait > 0) gnt_wait--;
        else begin
          bus_gnt = 1'b1; rsp_pend = 1'b1; rsp_addr = bus_addr;
          rsp_wait = rsp_delay; gnt_wait = gnt_delay;
        end
      end
    end
  end

  // Bus model for the strict-priority DUT: immediate grant, response next cycle.
  logic s_pend = 1'b0;
  initial begin
    s_bus_gnt = 1'b0; s_bus_rvalid = 1'b0; s_bus_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      s_bus_gnt = 1'b0; s_bus_rvalid = 1'b0;
      if (s_pend) begin s_bus_rvalid = 1'b1; s_bus_rdata = 32'h1111_2222; s_pend = 1'b0; end
      else if (s_bus_req) begin s_bus_gnt = 1'b1; s_pend = 1'b1; end
    end
  end

  int s_nif = 0, s_nd = 0;
  always @(negedge clk) begin
    if (reset) begin
      if (s_if_done) s_nif++;
      if (s_d_done)  s_nd++;
    end
  end

  // Per-cycle recording of the main DUT, indexed by cycle from stimulus start.
  logic        breq [0:63];
  logic [31:0] baddr[0:63];
  logic        bwe  [0:63];
  logic [3:0]  bws  [0:63];
  logic [31:0] bwd  [0:63];
  int          ifd[$];
  int          dd[$];
  logic [31:0] if_next[$];
  logic        d_keep = 1'b0;

  task automatic clear_rec();
    ifd.delete(); dd.delete(); if_next.delete();
  endtask

  // Observe cycles first..last; requesters drop or update on their done edge.
  task automatic run(input int first, input int last);
    for (int c = first; c <= last; c++) begin
      logic sif, sd;
      @(negedge clk);
      breq[c] = bus_req; baddr[c] = bus_addr; bwe[c] = bus_we; bws[c] = bus_wstrb; bwd[c] = bus_wdata;
      sif = if_done; sd = d_done;
      if (sif) ifd.push_back(c);
      if (sd)  dd.push_back(c);
      @(posedge clk); #1;
      if (sd && !d_keep) d_req = 1'b0;
      if (sif) begin
        if (if_next.size() > 0) if_addr = if_next.pop_front();
        else begin
          if_req = 1'b0;
          if (d_keep) begin d_req = 1'b0; d_keep = 1'b0; end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    if_req = 1'b0; if_kill = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wstrb = 4'h0; d_wdata = 32'h0;
    s_if_req = 1'b0; s_d_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
    chk("rst_dones", {30'd0, if_done, d_done}, 32'd0);
    chk("rst_rdata", if_rdata | d_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: fetch only, minimum latency
    clear_rec();
    if_req = 1'b1; if_addr = 32'h0000_0100;
    push(1'b1, 32'h0000_0013);
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      chk("t1_if_busy", {31'd0, if_busy}, (c < 3) ? 32'd1 : 32'd0);
      chk("t1_if_done", {31'd0, if_done}, (c == 3) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    if_req = 1'b0;
    repeat (2) @(posedge clk); #1;

    // 2: simultaneous requests, data first
    clear_rec();
    if_req = 1'b1; if_addr = 32'h0000_0104;
    d_req = 1'b1; d_addr = 32'h0000_2000; d_we = 1'b0;
    push(1'b0, 32'h5A5A_2000);
    push(1'b1, 32'h5A5A_0104);
    run(0, 9);
    chk("t2_data_req_c1", {31'd0, breq[1]}, 32'd1);
    chk("t2_data_addr_c1", baddr[1], 32'h0000_2000);
    chk("t2_fetch_req_c4", {31'd0, breq[4]}, 32'd0);
    chk("t2_fetch_req_c5", {31'd0, breq[5]}, 32'd1);
    chk("t2_fetch_addr_c5", baddr[5], 32'h0000_0104);
    chk("t2_d_done_cycle", (dd.size() > 0) ? dd[0] : -1, 32'd3);
    chk("t2_if_done_cycle", (ifd.size() > 0) ? ifd[0] : -1, 32'd7);

    // 3: continuous data with fetch waiting; fetch forced after 4 data grants
    clear_rec();
    d_keep = 1'b1;
    d_req = 1'b1; d_addr = 32'h0000_2000;
    if_req = 1'b1; if_addr = 32'h0000_0108;
    if_next.push_back(32'h0000_010C);
    repeat (4) push(1'b0, 32'h5A5A_2000);
    push(1'b1, 32'h5A5A_0108);
    repeat (4) push(1'b0, 32'h5A5A_2000);
    push(1'b1, 32'h5A5A_010C);
    run(0, 44);
    chk("t3_if_done_count", ifd.size(), 32'd2);
    chk("t3_if_done_first", (ifd.size() > 0) ? ifd[0] : -1, 32'd19);
    chk("t3_if_done_second", (ifd.size() > 1) ? ifd[1] : -1, 32'd39);
    chk("t3_d_done_count", dd.size(), 32'd8);

    // 4: fetch killed while waiting for grant
    clear_rec();
    if_req = 1'b1; if_addr = 32'h0000_0110;
    gnt_wait = 3;
    push(1'b1, 32'h5A5A_0114);
    run(0, 1);
    if_kill = 1'b1;
    run(2, 2);
    if_kill = 1'b0; if_addr = 32'h0000_0114;
    run(3, 12);
    for (int c = 1; c <= 4; c++) chk("t4_bus_req_held", {31'd0, breq[c]}, 32'd1);
    chk("t4_bus_req_dropped", {31'd0, breq[5]}, 32'd0);
    chk("t4_addr_held", baddr[4], 32'h0000_0110);
    chk("t4_refetch_addr", baddr[8], 32'h0000_0114);
    chk("t4_if_done_count", ifd.size(), 32'd1);
    chk("t4_if_done_cycle", (ifd.size() > 0) ? ifd[0] : -1, 32'd10);

    // 5: store with delayed grant, payload stable through REQ
    clear_rec();
    d_req = 1'b1; d_addr = 32'h0000_0040; d_we = 1'b1; d_wstrb = 4'b0011; d_wdata = 32'hDEAD_BEEF;
    gnt_wait = 2;
    push(1'b0, 32'h5A5A_0040);
    run(0, 7);
    d_we = 1'b0; d_wstrb = 4'h0; d_wdata = 32'h0;
    for (int c = 1; c <= 3; c++) begin
      chk("t5_bus_req", {31'd0, breq[c]}, 32'd1);
      chk("t5_bus_addr", baddr[c], 32'h0000_0040);
      chk("t5_bus_we", {31'd0, bwe[c]}, 32'd1);
      chk("t5_bus_wstrb", {28'd0, bws[c]}, 32'd3);
      chk("t5_bus_wdata", bwd[c], 32'hDEAD_BEEF);
    end
    chk("t5_d_done_cycle", (dd.size() > 0) ? dd[0] : -1, 32'd5);

    // Strict data priority: fetch never granted under continuous data
    s_nif = 0; s_nd = 0;
    s_d_req = 1'b1; s_if_req = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    s_d_req = 1'b0; s_if_req = 1'b0;
    chk("strict_if_done_count", s_nif, 32'd0);
    chk("strict_d_done_count", s_nd, 32'd10);
    repeat (6) @(posedge clk); #1;

    // 6: async reset during RSP, then a stale rvalid
    clear_rec();
    if_req = 1'b1; if_addr = 32'h0000_0118;
    rsp_delay = 3;
    run(0, 2);
    rsp_delay = 0;
    reset = 1'b0; if_req = 1'b0;
    #1;
    chk("t6_rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("t6_rst_bus_addr", bus_addr, 32'd0);
    chk("t6_rst_d_rdata", d_rdata, 32'd0);
    chk("t6_rst_if_done", {31'd0, if_done}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    run(4, 9);
    chk("t6_stale_rvalid_seen", {31'd0, rsp_pend}, 32'd0);
    for (int c = 4; c <= 9; c++) chk("t6_idle_bus_req", {31'd0, breq[c]}, 32'd0);
    chk("t6_no_done", ifd.size() + dd.size(), 32'd0);

    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
